ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver with a glitch-filtered clock line and a show-ahead byte FIFO.
// Frames (start, 8 data LSB first, odd parity, stop) are decoded on filtered
// ps2_clk falling edges; good bytes are queued, bad frames raise sticky flags.
module ps2_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  nextdata_n,
    output logic [7:0]            data,
    output logic                  ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  parity_err,
    output logic                  frame_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned FCW   = $clog2(FILTER_LEN);
    localparam int unsigned TOW   = 20;

    localparam logic [DEPTH_LOG2:0] DEPTH_LV  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FCW-1:0]      FILT_MAX  = FCW'(FILTER_LEN - 1);
    localparam logic [TOW-1:0]      IDLE_LAST = TOW'(TIMEOUT - 1);

    // synchronisers
    logic clk_s1, clk_s2;
    logic dat_s1, dat_s2;

    // clock filter
    logic           filt_clk;
    logic           filt_prev;
    logic [FCW-1:0] filt_cnt;
    logic           sample_evt;

    // receiver
    logic [3:0]     bit_cnt;
    logic [9:0]     shreg;
    logic [TOW-1:0] idle_cnt;
    logic           frame_done;
    logic           start_ok;
    logic           stop_ok;
    logic           par_ok;
    logic           frame_valid;
    logic           frame_bad;
    logic           par_bad;
    logic           timeout_hit;

    // fifo
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_nxt;
    logic                  push;
    logic                  pop;

    // Two-flop synchronisers on both PS/2 lines; idle-high after reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock follows the synchronised line only after FILTER_LEN
    // consecutive differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (clr) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign sample_evt = filt_prev & ~filt_clk;

    // Frame evaluation on the stop-bit sample; shreg[0] holds the start bit.
    always_comb begin
        frame_done  = sample_evt && (bit_cnt == 4'd10);
        start_ok    = ~shreg[0];
        stop_ok     = dat_s2;
        par_ok      = ^shreg[9:1];
        frame_valid = frame_done & start_ok & stop_ok & par_ok;
        frame_bad   = frame_done & ~(start_ok & stop_ok);
        par_bad     = frame_done & start_ok & stop_ok & ~par_ok;
        timeout_hit = (bit_cnt != 4'd0) && !sample_evt && (idle_cnt == IDLE_LAST);
    end

    // Bit counter, right-shifting capture register and idle watchdog.
    always_ff @(posedge clk) begin
        if (clr) begin
            bit_cnt  <= '0;
            idle_cnt <= '0;
            shreg    <= '0;
        end else if (sample_evt) begin
            idle_cnt <= '0;
            if (bit_cnt == 4'd10) begin
                bit_cnt <= '0;
            end else begin
                shreg   <= {dat_s2, shreg[9:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else if (bit_cnt != 4'd0) begin
            if (timeout_hit) begin
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end else begin
            idle_cnt <= '0;
        end
    end

    // Push is allowed into a full FIFO only when a pop frees a slot this cycle.
    always_comb begin
        pop       = ~nextdata_n & ready;
        push      = frame_valid & ((level < DEPTH_LV) | pop);
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end
    end

    // Sticky error flags, cleared only by clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (frame_bad || timeout_hit) begin
                frame_err <= 1'b1;
            end
            if (par_bad) begin
                parity_err <= 1'b1;
            end
            if (frame_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because data is gated by ready.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= shreg[8:1];
        end
    end

    // Pointers and registered occupancy.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_nxt;
            ready <= (level_nxt != '0);
        end
    end

    // Show-ahead head byte, zero while empty.
    always_comb begin
        data = 8'h00;
        if (ready) begin
            data = mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed scenarios plus randomized
// frames, compared against a queue-based model of the receiver and FIFO.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int FLEN  = 4;
    localparam int TMO   = 300;
    localparam int HP    = 12;

    logic       clk = 1'b0;
    logic       clr;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic [3:0] level;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mq[$];
    logic m_ovf, m_par, m_frm;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DEPTH_LOG2 (3),
        .FILTER_LEN (FLEN),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .level      (level),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_data;
        @(negedge clk);
        exp_data = (mq.size() != 0) ? mq[0] : 8'h00;
        check_val({tag, "/level"}, 32'(level), 32'(mq.size()));
        check_val({tag, "/ready"}, 32'(ready), 32'(mq.size() != 0));
        check_val({tag, "/data"}, 32'(data), 32'(exp_data));
        check_val({tag, "/ovf"}, 32'(overflow), 32'(m_ovf));
        check_val({tag, "/par"}, 32'(parity_err), 32'(m_par));
        check_val({tag, "/frm"}, 32'(frame_err), 32'(m_frm));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wait_cyc(1);
        clr = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        nextdata_n = 1'b1;
        wait_cyc(2);
        clr = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_par = 1'b0;
        m_frm = 1'b0;
    endtask

    // Frame-level reference: odd parity over data+parity, start 0, stop 1.
    task automatic model_frame(input logic [10:0] bits, input bit popped);
        bit pop_ok;
        bit push_ok;
        pop_ok  = popped && (mq.size() != 0);
        push_ok = 1'b0;
        if (bits[0] != 1'b0 || bits[10] != 1'b1) begin
            m_frm = 1'b1;
        end else if (($countones(bits[9:1]) % 2) == 0) begin
            m_par = 1'b1;
        end else if (mq.size() < DEPTH || pop_ok) begin
            push_ok = 1'b1;
        end else begin
            m_ovf = 1'b1;
        end
        if (pop_ok) void'(mq.pop_front());
        if (push_ok) mq.push_back(bits[8:1]);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_start, input bit bad_stop,
                              input bit par_flip, input bit pop_at_end,
                              input int nbits, input int glitch_bit);
        logic [10:0] bits;
        logic par;
        par  = (~(^d)) ^ par_flip;
        bits = {~bad_stop, par, d, bad_start};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(HP / 2);
            if (i == glitch_bit) begin
                ps2_clk = 1'b0;
                wait_cyc(1);
                ps2_clk = 1'b1;
            end
            wait_cyc(HP / 2);
            ps2_clk = 1'b0;
            if (i == 10 && pop_at_end) begin
                // stop-bit sample lands 7 edges after the fall (2 sync + FLEN filter + 1 edge detect)
                wait_cyc(FLEN + 2);
                nextdata_n = 1'b0;
                @(posedge clk);
                model_frame(bits, 1'b1);
                #1;
                nextdata_n = 1'b1;
                wait_cyc(HP - FLEN - 3);
            end else begin
                wait_cyc(HP);
                if (i == 10) model_frame(bits, 1'b0);
            end
            ps2_clk = 1'b1;
        end
        wait_cyc(HP);
    endtask

    task automatic pop_pulse();
        wait_cyc(1);
        nextdata_n = 1'b0;
        @(posedge clk);
        if (mq.size() != 0) void'(mq.pop_front());
        #1;
        nextdata_n = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int kind;
        int npop;
        logic [7:0] d;
        clr = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        nextdata_n = 1'b1;

        // reset state and single frame
        do_reset();
        check_all("rst");
        check_val("rst/data0", 32'(data), 32'h00);
        send_frame(8'h1C, 0, 0, 0, 0, 11, -1);
        check_all("f1c");
        check_val("f1c/byte", 32'(data), 32'h1C);
        pop_pulse();
        check_all("f1c_pop");

        // overflow with DEPTH+1 frames
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0, 0, 11, -1);
        check_all("ovf");
        check_val("ovf/lvl8", 32'(level), 32'd8);
        for (int i = 0; i < 9; i++) begin
            pop_pulse();
            check_all("ovf_pop");
        end

        // parity and stop errors
        do_reset();
        send_frame(8'h1C, 0, 0, 1, 0, 11, -1);
        check_all("perr");
        send_frame(8'h32, 0, 1, 0, 0, 11, -1);
        check_all("ferr");

        // timeout abort then recovery
        do_reset();
        send_frame(8'h5A, 0, 0, 0, 0, 5, -1);
        wait_cyc(TMO + 100);
        m_frm = 1'b1;
        check_all("tmo");
        send_frame(8'h5A, 0, 0, 0, 0, 11, -1);
        check_all("tmo_next");

        // glitch rejection
        do_reset();
        send_frame(8'h1C, 0, 0, 0, 0, 11, 3);
        check_all("glitch");

        // full FIFO with pop coincident with push
        do_reset();
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 0, 0, 0, 0, 11, -1);
        send_frame(8'hAA, 0, 0, 0, 1, 11, -1);
        check_all("fullpop");
        for (int i = 0; i < 8; i++) begin
            pop_pulse();
            check_all("fullpop_drain");
        end

        // clr mid-frame discards the partial frame
        send_frame(8'hFF, 0, 0, 0, 0, 4, -1);
        do_reset();
        send_frame(8'h3C, 0, 0, 0, 0, 11, -1);
        check_all("midclr");

        // randomized traffic
        do_reset();
        for (int it = 0; it < 60; it++) begin
            d    = 8'($urandom);
            kind = $urandom_range(0, 9);
            send_frame(d, kind == 8, kind == 9, kind == 7,
                       $urandom_range(0, 7) == 0, 11, -1);
            check_all("rnd");
            npop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            for (int p = 0; p < npop; p++) begin
                pop_pulse();
                check_all("rnd_pop");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
